atm_cash_arbiter: RTL and testbench

ATM_CASH_ARBITER -- requirements
Module: atm_cash_arbiter

---
 rtl/atm_cash_arbiter.sv | 110 +++++++++++
 tb/tb_atm_cash_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_cash_arbiter.sv
// ATM cash dispenser arbiter: round-robin session grant, per-note dispense,
// saturating vault counter with refill.
module atm_cash_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int AMT_W      = 8,
  parameter int VAULT_W    = 16,
  parameter int VAULT_INIT = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*AMT_W-1:0] amount,
  input  logic                     refill,
  input  logic [VAULT_W-1:0]       refill_amt,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       reject,
  output logic                     note_out,
  output logic                     busy,
  output logic [VAULT_W-1:0]       vault_level
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, DISPENSE, DONE, REJECT
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]      owner, last_owner, pick;
  logic               found;
  logic [AMT_W-1:0]   amt_q, cnt;
  logic [VAULT_W-1:0] vault, vault_nxt, amt_ext;
  logic [VAULT_W:0]   vault_sum;
  logic               fits;
  logic [NUM_REQ-1:0] owner_oh;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(last_owner) + 1 + i) % NUM_REQ]) begin
        pick  = IW'((int'(last_owner) + 1 + i) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  assign amt_ext = VAULT_W'(amt_q);
  assign fits    = (amt_q != '0) && (amt_ext <= vault);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (found) state_nxt = CHECK;
      CHECK:    state_nxt = fits ? DISPENSE : REJECT;
      DISPENSE: if (cnt == AMT_W'(1)) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      REJECT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Note and refill in the same cycle both apply; only overflow saturates.
  assign vault_sum = {1'b0, vault}
                   - {{VAULT_W{1'b0}}, note_out}
                   + (refill ? {1'b0, refill_amt} : '0);
  assign vault_nxt = vault_sum[VAULT_W] ? '1 : vault_sum[VAULT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      amt_q      <= '0;
      cnt        <= '0;
      vault      <= VAULT_W'(VAULT_INIT);
    end else begin
      vault <= vault_nxt;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            amt_q <= amount[int'(pick)*AMT_W +: AMT_W];
          end
        end
        CHECK:    cnt <= amt_q;
        DISPENSE: cnt <= cnt - AMT_W'(1);
        DONE:     last_owner <= owner;
        REJECT:   last_owner <= owner;
        default:  ;
      endcase
    end
  end

  assign owner_oh    = NUM_REQ'(1) << owner;
  assign busy        = (state != IDLE);
  assign note_out    = (state == DISPENSE);
  assign grant       = busy ? owner_oh : '0;
  assign done        = (state == DONE) ? owner_oh : '0;
  assign reject      = (state == REJECT) ? owner_oh : '0;
  assign vault_level = vault;

endmodule

// File: tb/tb_atm_cash_arbiter.sv
// Scoreboard bench for atm_cash_arbiter: expected session outcomes are queued
// at drive time and retired when done/reject pulses.
module tb_atm_cash_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*AW-1:0] amount = '0;
  logic          refill = 1'b0;
  logic [VW-1:0] refill_amt = '0;
  logic [N-1:0]  grant, done, reject;
  logic          note_out, busy;
  logic [VW-1:0] vault_level;

  atm_cash_arbiter #(
    .NUM_REQ(N), .AMT_W(AW), .VAULT_W(VW), .VAULT_INIT(1000)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount),
    .refill(refill), .refill_amt(refill_amt),
    .grant(grant), .done(done), .reject(reject),
    .note_out(note_out), .busy(busy), .vault_level(vault_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int owner;
    bit ok;
    int notes;
    int vault;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_vault = 1000;
  int nseen   = 0;
  int gcyc    = 0;
  logic [N-1:0] gprev = '0;
  logic [N-1:0] gown  = '0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (note_out) nseen++;
    if (grant != '0 && gprev == '0) begin
      gcyc = cyc;
      gown = grant;
    end
    gprev = grant;
    if ((done | reject) != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_end", longint'(done | reject), 0);
      end else begin
        e = sb.pop_front();
        check("end_owner", longint'(done | reject), longint'(1) << e.owner);
        check("end_kind", longint'(done != '0), longint'(e.ok));
        check("grant_owner", longint'(gown), longint'(1) << e.owner);
        check("notes", nseen, e.notes);
        check("vault_end", longint'(vault_level), e.vault);
        check("grant_to_end", cyc - gcyc, e.ok ? e.notes + 1 : 1);
      end
      nseen = 0;
    end else if (!busy) begin
      nseen = 0;
    end
  end

  task automatic push_raw(input int own, input bit ok, input int notes,
                          input int vault);
    exp_t t;
    t.owner = own;
    t.ok    = ok;
    t.notes = notes;
    t.vault = vault;
    sb.push_back(t);
  endtask

  task automatic push(input int own, input int amt);
    bit ok;
    ok = (amt != 0) && (amt <= exp_vault);
    if (ok) exp_vault -= amt;
    push_raw(own, ok, ok ? amt : 0, exp_vault);
  endtask

  task automatic set_amount(input int amt);
    logic [AW-1:0] a;
    a = AW'(amt);
    amount = {N{a}};
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", longint'(k < 600), 1);
  endtask

  task automatic session(input logic [N-1:0] r, input int own, input int amt);
    int k;
    push(own, amt);
    @(posedge clk); #1;
    req = r;
    set_amount(amt);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    check("req_to_grant", k, 1);
    req = '0;
    set_amount(8'h5A);
    wait_idle();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_vault = 1000;
  endtask

  task automatic pulse_refill(input logic [VW-1:0] amt);
    @(posedge clk); #1;
    refill = 1'b1;
    refill_amt = amt;
    @(posedge clk); #1;
    refill = 1'b0;
    @(negedge clk);
  endtask

  int bc;
  logic [N-1:0] ends;

  initial begin
    @(negedge clk);
    check("rst_grant", longint'(grant), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_note", longint'(note_out), 0);
    check("rst_done_rej", longint'(done | reject), 0);
    check("rst_vault", longint'(vault_level), 1000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", longint'(busy), 0);

    session(4'b0001, 0, 3);
    check("vault_997", longint'(vault_level), 997);

    do_reset();
    for (int i = 0; i < 5; i++) push(i % N, 1);
    @(posedge clk); #1;
    req = 4'b1111;
    set_amount(1);
    bc = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) bc++;
    end
    @(posedge clk); #1;
    req = '0;
    check("rr_busy_cycles", bc, 15);
    wait_idle();
    check("rr_queue_empty", sb.size(), 0);

    session(4'b1001, 3, 255);
    session(4'b0011, 0, 255);
    session(4'b0110, 1, 255);
    session(4'b0100, 2, 223);
    check("vault_7", longint'(vault_level), 7);
    session(4'b1000, 3, 7);
    check("vault_empty", longint'(vault_level), 0);
    session(4'b0001, 0, 1);

    pulse_refill(16'd5);
    check("refill_5", longint'(vault_level), 5);
    exp_vault = 5;
    session(4'b0010, 1, 6);
    session(4'b0010, 1, 0);
    check("vault_still_5", longint'(vault_level), 5);

    pulse_refill(16'hFFEB);
    check("refill_fff0", longint'(vault_level), 'hFFF0);
    push_raw(2, 1'b1, 20, 'hFFEC);
    exp_vault = 'hFFEC;
    @(posedge clk); #1;
    req = 4'b1111;
    set_amount(20);
    @(negedge clk);
    @(negedge clk);
    check("sat_grant", longint'(grant), 4);
    @(posedge clk); #1;
    refill = 1'b1;
    refill_amt = 16'h0100;
    @(negedge clk);
    check("sat_note", longint'(note_out), 1);
    @(posedge clk); #1;
    refill = 1'b0;
    req = '0;
    @(negedge clk);
    check("sat_ffff", longint'(vault_level), 'hFFFF);
    wait_idle();

    @(posedge clk); #1;
    req = 4'b1111;
    set_amount(10);
    repeat (6) @(negedge clk);
    check("pre_rst_note", longint'(note_out), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_grant", longint'(grant), 0);
    check("arst_note", longint'(note_out), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_vault", longint'(vault_level), 1000);
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    ends = '0;
    repeat (4) begin
      @(negedge clk);
      ends = ends | done | reject;
    end
    check("no_end_after_rst", longint'(ends), 0);
    check("final_queue", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
